// File: rtl/alu_issue.sv
// Request FIFO and sequencer in front of a registered 1-cycle ALU.
// Requests are issued one at a time and answered strictly in order. Illegal select codes are answered directly, without using the ALU.
`timescale 1ns/1ps
module alu_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic [4:0]        req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [4:0]        alu_sel,
  input  logic [31:0]       alu_out,
  input  logic              alu_complete,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [4:0]  OP_MAX  = 5'b10011;
  localparam logic [4:0]  OP_DIV  = 5'b00011;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [4:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]      count_reg;
  state_t           state_reg, state_next;

  logic [31:0]      alu_a_reg, alu_b_reg, rsp_data_reg;
  logic [4:0]       alu_sel_reg;
  logic             rsp_zero_reg, rsp_err_reg;
  logic [TAG_W-1:0] rsp_tag_reg;
  logic [15:0]      ops_done_reg;

  req_t head;
  logic fifo_ne, head_legal, push, pop, rsp_fire;

  assign head       = mem[rd_ptr_reg];
  assign fifo_ne    = (count_reg != '0);
  assign head_legal = (head.op <= OP_MAX);
  // Readiness depends on the registered count only, so a pop this cycle never frees space combinationally.
  assign req_ready  = rst_n && (count_reg < DEPTH_C);
  assign push       = req_valid && req_ready;
  assign rsp_fire   = (state_reg == RESP) && rsp_ready;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_ne) begin
          pop        = 1'b1;
          state_next = head_legal ? ISSUE : RESP;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: if (alu_complete) state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (fifo_ne) begin
            pop        = 1'b1;
            state_next = head_legal ? ISSUE : RESP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {req_a, req_b, req_op, req_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_sel_reg  <= '0;
      rsp_data_reg <= '0;
      rsp_zero_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
      rsp_tag_reg  <= '0;
      ops_done_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

      // Tag and error flag are settled at pop; they are not visible until RESP.
      if (pop) begin
        rsp_tag_reg <= head.tag;
        if (head_legal) begin
          alu_a_reg   <= head.a;
          alu_b_reg   <= head.b;
          alu_sel_reg <= head.op;
          rsp_err_reg <= (head.op == OP_DIV) && (head.b == '0);
        end else begin
          rsp_data_reg <= '0;
          rsp_zero_reg <= 1'b1;
          rsp_err_reg  <= 1'b1;
        end
      end

      // Zero is derived from the captured result; the ALU's own flag refers to the previous op.
      if ((state_reg == CAPTURE) && alu_complete) begin
        rsp_data_reg <= alu_out;
        rsp_zero_reg <= (alu_out == '0);
      end

      if (rsp_fire) ops_done_reg <= ops_done_reg + 16'd1;
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_tag   = rsp_tag_reg;
  assign ops_done  = ops_done_reg;
  assign busy      = (state_reg != IDLE) || fifo_ne;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a behavioural ALU, an in-order response scoreboard, directed cases, and a randomized stall/backpressure phase.
`timescale 1ns/1ps
module tb_alu_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0] req_op = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0] alu_a, alu_b;
  logic [4:0] alu_sel;
  logic [31:0] alu_out = '0;
  logic alu_complete = 1'b0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic rsp_zero, rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic busy;
  logic [15:0] ops_done;
  logic stall_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_complete(alu_complete),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    logic [31:0] r;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a * b;
      5'd3:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7:  r = a << b[4:0];
      5'd8:  r = a >> b[4:0];
      5'd9:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd11: r = (a < b) ? 32'd1 : 32'd0;
      5'd12: r = ~(a | b);
      5'd13: r = b;
      5'd14: r = a;
      5'd15: r = ~a;
      5'd16: r = a + 32'd1;
      5'd17: r = a - 32'd1;
      5'd18: r = (a == b) ? 32'd1 : 32'd0;
      5'd19: r = {a[15:0], b[15:0]};
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  // External ALU: result registered from the presented operands; completion may be withheld.
  always @(posedge clk) begin
    alu_out      <= alu_fn(alu_a, alu_b, alu_sel);
    alu_complete <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic zero;
    logic err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  rsp_t exp_q[$];
  int rsp_cyc[$];
  logic [15:0] ops_model = '0;

  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] op, input logic [TAG_W-1:0] tag);
    rsp_t r;
    r.tag = tag;
    if (op > 5'd19) begin
      r.data = '0; r.zero = 1'b1; r.err = 1'b1;
    end else begin
      r.data = alu_fn(a, b, op);
      r.zero = (r.data == 0);
      r.err  = (op == 5'd3) && (b == 0);
    end
    return r;
  endfunction

  // Scoreboard: sampled on the falling edge, between driver updates.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst_n) begin
      exp_q.delete();
      ops_model = '0;
    end else begin
      chk("ops_done", ops_done, ops_model);
      chk("busy", busy, exp_q.size() != 0);
      if (exp_q.size() >= DEPTH + 1) chk("full_ready", req_ready, 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_zero", rsp_zero, e.zero);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_tag", rsp_tag, e.tag);
          $display("rsp tag=%0d data=%08h zero=%0d err=%0d", rsp_tag, rsp_data, rsp_zero, rsp_err);
        end
        ops_model = ops_model + 16'd1;
        rsp_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(model(req_a, req_b, req_op, req_tag));
        $display("req tag=%0d op=%0d a=%08h b=%08h", req_tag, req_op, req_a, req_b);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input logic [TAG_W-1:0] tag);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_tag = tag;
  endtask

  // Present one request from idle, then count edges from acceptance until rsp_valid rises.
  task automatic send_lat(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic [TAG_W-1:0] tag, input int exp_lat);
    int lat, g;
    drive(a, b, op, tag);
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin
      @(negedge clk); g++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic wait_idle(input int limit);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < limit) begin
      @(negedge clk); g++;
    end
    chk("drain", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int acc, sent, guard, base;
    logic last_ready, took;

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    @(posedge clk); #1;

    // Directed single requests
    send_lat(32'd5, 32'd7, 5'b00000, 4'd3, 3);
    chk("add_data", rsp_data, 12);
    chk("add_tag", rsp_tag, 3);
    wait_idle(20);
    send_lat(32'd9, 32'd9, 5'b00001, 4'd1, 3);
    chk("sub_data", rsp_data, 0);
    chk("sub_zero", rsp_zero, 1);
    wait_idle(20);
    send_lat(32'd10, 32'd0, 5'b00011, 4'd2, 3);
    chk("div0_data", rsp_data, 32'hFFFF_FFFF);
    chk("div0_err", rsp_err, 1);
    wait_idle(20);
    send_lat(32'd10, 32'd20, 5'b11000, 4'd4, 1);
    chk("ill_data", rsp_data, 0);
    chk("ill_err", rsp_err, 1);
    chk("ill_sel_held", alu_sel, 5'b00011);
    wait_idle(20);

    // Back-pressure: five outstanding, the sixth refused
    rsp_ready = 1'b0;
    acc = 0; last_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(32'(i), 32'd100, 5'b00000, TAG_W'(i));
      @(negedge clk);
      last_ready = req_ready;
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_sixth_ready", last_ready, 0);
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle(60);
    chk("bp_ops_done", ops_done, 9);

    // Throughput: four back-to-back ADDs with the consumer always ready
    base = rsp_cyc.size();
    for (int i = 0; i < 4; i++) begin
      drive(32'(i * 3), 32'd7, 5'b00000, TAG_W'(8 + i));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_idle(60);
    for (int i = 0; i < 3; i++)
      chk("tput_spacing", rsp_cyc[base + i + 1] - rsp_cyc[base + i], 3);
    chk("tput_ops_done", ops_done, 13);

    // Reset while an op sits in CAPTURE with two more queued
    for (int i = 0; i < 3; i++) begin
      drive(32'd50, 32'(i), 5'b00000, TAG_W'(i));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ops", ops_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy2", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    send_lat(32'd1, 32'd1, 5'b00000, 4'd6, 3);
    chk("post_rst_add", rsp_data, 2);
    wait_idle(20);

    // Randomized traffic with ALU stalls and consumer back-pressure
    stall_en = 1'b1;
    sent = 0; guard = 0; took = 1'b0;
    while (sent < 200 && guard < 6000) begin
      @(posedge clk); #1; guard++;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid || took) begin
        if ($urandom_range(0, 3) == 0) begin
          req_valid = 1'b0;
        end else begin
          req_a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
          req_b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 5) == 0) ? req_a : $urandom);
          req_op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
          req_tag = TAG_W'($urandom);
          req_valid = 1'b1;
        end
      end
      @(negedge clk);
      took = req_valid && req_ready;
      if (took) sent++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(2000);
    chk("rand_sent", sent, 200);
    chk("rand_ops_done", ops_done, 16'd201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
